key_debounce_ctrl: RTL
======================

# key_debounce_ctrl

Multi-key debounce and event generator that sits directly upstream of the LED flow controller. It takes raw, bouncing, active-low push-button inputs and synchronises each one. Each key is then filtered through a per-key state machine, and the block emits clean level and single-cycle press/release/long-press events. The LED controller consumes these events for mode, direction and speed changes.

## Interface
- KEY_NUM, 4 — number of keys.
- DEB_WIDTH, 20 — debounce counter width.
- DEB_MAX, 1_000_000 — stable cycles required to accept a change (20 ms at 50 MHz).
- LONG_WIDTH, 26 — long-press counter width.
- LONG_MAX, 50_000_000 — held cycles for a long press (1 s at 50 MHz).

- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- key  in  KEY_NUM  raw key inputs, active-low (0 = pressed), asynchronous to sys_clk.
- key_level  out  KEY_NUM  debounced state, 1 = pressed.
- key_press  out  KEY_NUM  one-cycle pulse on accepted press.
- key_release  out  KEY_NUM  one-cycle pulse on accepted release.
- key_long  out  KEY_NUM  one-cycle pulse when the hold reaches LONG_MAX.
- key_valid  out  1  one-cycle pulse when any key_press bit is set.
- key_code  out  2  index of the pressed key; registered with key_valid and held until the next key_valid.

## Operation
- **Synchroniser:** two-flop synchroniser per key. Reset value is 1 (released). The synchronised value is inverted to give the internal pressed flag p.
- **Per-key FSM:** four states.
  - IDLE (released): p = 1 → PRESS_FILT, clear counter.
  - PRESS_FILT: p = 0 → IDLE (bounce). While p = 1, counter increments. When counter == DEB_MAX-1 and p = 1 → DOWN.
  - DOWN: p = 0 → REL_FILT, clear counter.
  - REL_FILT: p = 1 → DOWN (bounce). While p = 0, counter increments. When counter == DEB_MAX-1 and p = 0 → IDLE.
- **key_level:** 1 in DOWN and REL_FILT, 0 in IDLE and PRESS_FILT.
- **key_press:** asserted for exactly the one cycle in which key_level first reads 1 after PRESS_FILT→DOWN.
- **key_release:** asserted for exactly the one cycle in which key_level first reads 0 after REL_FILT→IDLE.
- **Long press:** the long counter runs only in DOWN and REL_FILT, starting at the PRESS_FILT→DOWN transition. When it reaches LONG_MAX-1, key_long pulses once, then the counter saturates. At most one key_long per press. The counter clears on entry to IDLE.
- **Counter arithmetic:** unsigned. The debounce counter never exceeds DEB_MAX-1. Widths must satisfy 2^DEB_WIDTH ≥ DEB_MAX and 2^LONG_WIDTH ≥ LONG_MAX.
- **Simultaneous presses:** key_valid = OR of key_press. key_code = lowest index set in that cycle; higher-index presses in the same cycle are reported on key_press only.
- **Reset values:** all outputs 0, all FSMs IDLE, all counters 0, key_code 0.
- **Reset mid-operation:** everything returns immediately to the reset values with no pulses. A key still held after reset release is re-filtered and produces key_press after the full debounce delay.

## Timing
- Synchroniser latency: 2 cycles.
- Raw edge, then stable for ≥ DEB_MAX+2 cycles → key_level/key_press change DEB_MAX+2 to DEB_MAX+3 cycles after the edge, depending on sampling phase.
- A bounce shorter than DEB_MAX cycles produces no event and leaves key_level unchanged.
- key_long rises LONG_MAX cycles after key_press.
- key_valid and key_code are registered in the same cycle as key_press; there is no extra latency.
- There is no back-pressure. Consumers must sample the pulses in the cycle they are asserted.

## Configuration
- KEY_LONG_PRESS_EN defined: long counters and key_long logic are instantiated as described above.
- KEY_LONG_PRESS_EN undefined: long counters are removed, key_long is tied to 0, and the LONG_* parameters are ignored.

## Structure
- **Shared package (key_pkg):** FSM state enum (IDLE, PRESS_FILT, DOWN, REL_FILT) and default timing constants (DEB_MAX_20MS, LONG_MAX_1S).
- **Sub-module key_filter_single:** per-key synchroniser, FSM, debounce counter and long counter. Generated KEY_NUM times.
- **Top level:** holds only key_valid/key_code aggregation.

## Test plan
Bench parameters: DEB_MAX=8, LONG_MAX=32.
- Clean press of key[1] held for 20 cycles → key_press[1] pulses once, about 10 cycles after the edge. key_valid=1 and key_code=1 in the same cycle. key_level[1]=1.
- key[0] toggles every 3 cycles for 30 cycles, then returns high → no pulses on any output; key_level stays 0.
- key[2] held for 50 cycles → key_long[2] pulses once, 32 cycles after key_press[2]. With the macro undefined, key_long stays 0.
- key[3] and key[1] pressed in the same cycle → key_press=4'b1010, a single key_valid pulse, key_code=1.
- Release of key[1] with 4-cycle bounce, then stable high → one key_release[1] pulse about 10 cycles after the last bounce.
- sys_rst_n asserted while key[0] is in DOWN, released while the key is still held → outputs 0 during reset. A new key_press[0] follows about 10 cycles after reset release, with no key_release.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key debounce slice.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILT,
    DOWN,
    REL_FILT
  } key_state_t;

  localparam int unsigned DEB_MAX_20MS = 1_000_000;
  localparam int unsigned LONG_MAX_1S  = 50_000_000;

  function automatic logic is_held(input key_state_t s);
    return (s == DOWN) || (s == REL_FILT);
  endfunction

endpackage

// File: rtl/key_filter_single.sv
// One key: 2-flop synchroniser, debounce FSM, press/release events and
// optional long-press detection (KEY_LONG_PRESS_EN).
module key_filter_single
  import key_pkg::*;
#(
  parameter int unsigned DEB_WIDTH  = 20,
  parameter int unsigned DEB_MAX    = DEB_MAX_20MS,
  parameter int unsigned LONG_WIDTH = 26,
  parameter int unsigned LONG_MAX   = LONG_MAX_1S
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic press_evt
);

  localparam logic [DEB_WIDTH-1:0] DEB_LAST = DEB_WIDTH'(DEB_MAX - 1);

  if ((DEB_MAX == 0) || (64'(DEB_MAX) > (64'd1 << DEB_WIDTH))) begin : g_deb_range_bad
    $error("DEB_MAX out of range for DEB_WIDTH");
  end
  if ((LONG_MAX == 0) || (64'(LONG_MAX) > (64'd1 << LONG_WIDTH))) begin : g_long_range_bad
    $error("LONG_MAX out of range for LONG_WIDTH");
  end

  logic [1:0] sync_q;
  logic       pressed;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sync_q <= '1;
    else            sync_q <= {sync_q[0], key};
  end

  assign pressed = ~sync_q[1];

  key_state_t           state, state_nxt;
  logic [DEB_WIDTH-1:0] deb_cnt, deb_cnt_nxt;
  logic                 release_evt;

  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    unique case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt   = PRESS_FILT;
          deb_cnt_nxt = '0;
        end
      end
      PRESS_FILT: begin
        if (!pressed)                state_nxt   = IDLE;
        else if (deb_cnt == DEB_LAST) state_nxt  = DOWN;
        else                         deb_cnt_nxt = deb_cnt + 1'b1;
      end
      DOWN: begin
        if (!pressed) begin
          state_nxt   = REL_FILT;
          deb_cnt_nxt = '0;
        end
      end
      REL_FILT: begin
        if (pressed)                 state_nxt   = DOWN;
        else if (deb_cnt == DEB_LAST) state_nxt  = IDLE;
        else                         deb_cnt_nxt = deb_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Events are decoded from the transition so they register alongside key_level.
  assign press_evt   = (state == PRESS_FILT) && (state_nxt == DOWN);
  assign release_evt = (state == REL_FILT)   && (state_nxt == IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      deb_cnt     <= deb_cnt_nxt;
      key_level   <= is_held(state_nxt);
      key_press   <= press_evt;
      key_release <= release_evt;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [LONG_WIDTH-1:0] LONG_LAST = LONG_WIDTH'(LONG_MAX - 1);

  logic [LONG_WIDTH-1:0] long_cnt;
  logic                  long_done;

  // Counting only while both current and next state are held makes the count
  // start on the press transition and clear on the edge that enters IDLE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else if (!(is_held(state) && is_held(state_nxt))) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (!long_done) begin
        if (long_cnt == LONG_LAST) begin
          key_long  <= 1'b1;
          long_done <= 1'b1;
        end else begin
          long_cnt <= long_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_ctrl.sv
// Multi-key debounce front end; aggregates per-key press events into
// key_valid/key_code. Long press enabled by KEY_LONG_PRESS_EN.
module key_debounce_ctrl
  import key_pkg::*;
#(
  parameter int unsigned KEY_NUM    = 4,
  parameter int unsigned DEB_WIDTH  = 20,
  parameter int unsigned DEB_MAX    = DEB_MAX_20MS,
  parameter int unsigned LONG_WIDTH = 26,
  parameter int unsigned LONG_MAX   = LONG_MAX_1S
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic               key_valid,
  output logic [1:0]         key_code
);

  if ((KEY_NUM == 0) || (KEY_NUM > 4)) begin : g_key_num_bad
    $error("KEY_NUM must be 1..4 for a 2-bit key_code");
  end

  logic [KEY_NUM-1:0] press_evt;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_filter_single #(
      .DEB_WIDTH (DEB_WIDTH),
      .DEB_MAX   (DEB_MAX),
      .LONG_WIDTH(LONG_WIDTH),
      .LONG_MAX  (LONG_MAX)
    ) u_filter (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key        (key[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .press_evt  (press_evt[i])
    );
  end

  logic [1:0] code_nxt;
  logic       found;

  always_comb begin
    code_nxt = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      if (press_evt[i] && !found) begin
        code_nxt = 2'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= |press_evt;
      if (|press_evt) key_code <= code_nxt;
    end
  end

endmodule
